// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of an N:1 W-bit mux with a registered valid/ready output stage.
// Optional port lock is compiled in when ARB_LOCK_EN is defined.
module mux_rr_arbiter #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             req,
  input  logic [N*W-1:0]           i_data,
  output logic [N-1:0]             ack,
  output logic [W-1:0]             y,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic [$clog2(N)-1:0]     sel,
`ifdef ARB_LOCK_EN
  input  logic                     lock,
`endif
  output logic                     busy
);

  localparam int SEL_W = $clog2(N);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       y_q, y_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic [N-1:0]       eligible;
  logic [SEL_W-1:0]   winner;
  logic [SEL_W-1:0]   idx;
  logic               found;
  logic               can_load;
  logic               capture;

`ifdef ARB_LOCK_EN
  logic               owner_vld_q, owner_vld_d;
  logic [SEL_W-1:0]   owner_q, owner_d;

  // A held lock narrows eligibility to the owning port only.
  always_comb begin
    eligible = req;
    if (owner_vld_q) begin
      eligible = req & ({{(N-1){1'b0}}, 1'b1} << owner_q);
    end
  end
`else
  always_comb begin
    eligible = req;
  end
`endif

  // Scan starts at ptr and wraps naturally because N is a power of two.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + SEL_W'(k);
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign can_load = (state_q == EMPTY) || y_ready;
  assign capture  = can_load && found;
  assign ack      = capture ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef ARB_LOCK_EN
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
`endif
    if (capture) begin
      state_d = FULL;
      y_d     = i_data[winner*W +: W];
      sel_d   = winner;
      ptr_d   = winner + SEL_W'(1);
`ifdef ARB_LOCK_EN
      owner_vld_d = lock;
      owner_d     = winner;
`endif
    end else if ((state_q == FULL) && y_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      y_q     <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
    end
  end
`endif

  assign y       = y_q;
  assign sel     = sel_q;
  assign y_valid = (state_q == FULL);
  assign busy    = (state_q == FULL);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table plus hand-written corner sequences,
// with a scoreboard queue holding the words the output stage is expected to present.
module tb_mux_rr_arbiter;

  localparam int N = 8;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*W-1:0] i_data;
  logic [N-1:0]  ack;
  logic [W-1:0]  y;
  logic          y_valid;
  logic          y_ready;
  logic [2:0]    sel;
  logic          busy;
  logic          lock;

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .i_data  (i_data),
    .ack     (ack),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .sel     (sel),
`ifdef ARB_LOCK_EN
    .lock    (lock),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [2:0] sel;
  } sbItem_t;

  typedef struct {
    logic [7:0]  req;
    logic [31:0] data;
    logic        rdy;
    logic [7:0]  expAck;
  } vec_t;

  sbItem_t    sbQueue[$];
  vec_t       vecs[9];
  int         assertCount = 0;
  int         failCount   = 0;
  logic [2:0] modelPtr;
  bit         modelOwnerValid;
  logic [2:0] modelOwner;

  task automatic checkEq(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Rotate a doubled copy so the lowest set bit is the first requester at or after p.
  function automatic int modelWinner(input logic [7:0] elig, input logic [2:0] p);
    logic [15:0] dbl;
    dbl = {elig, elig} >> p;
    for (int k = 0; k < 8; k++) begin
      if (dbl[k]) return (int'(p) + k) % 8;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [7:0] r, input logic [31:0] d, input logic rdy, input logic lk);
    req     = r;
    i_data  = d;
    y_ready = rdy;
    lock    = lk;
  endtask

  // Check the combinational ack, clock once, then compare the output stage with the scoreboard.
  task automatic checkOutput(input logic [7:0] expAck, input string name);
    logic [7:0] elig;
    int         w;
    bit         acceptNow;
    bit         captureNow;
    logic       lk;
    sbItem_t    item;
    #1;
    checkEq({name, " ack"}, 32'(ack), 32'(expAck));
    elig = modelOwnerValid ? (req & (8'd1 << modelOwner)) : req;
    acceptNow  = (sbQueue.size() != 0) && y_ready;
    captureNow = ((sbQueue.size() == 0) || y_ready) && (elig != 8'd0);
    lk = lock;
    w = 0;
    item.data = '0;
    item.sel  = '0;
    if (captureNow) begin
      w = modelWinner(elig, modelPtr);
      item.data = i_data[w*4 +: 4];
      item.sel  = 3'(w);
    end
    @(posedge clk);
    #1;
    if (acceptNow) void'(sbQueue.pop_front());
    if (captureNow) begin
      sbQueue.push_back(item);
      modelPtr        = 3'(w + 1);
      modelOwnerValid = lk;
      modelOwner      = 3'(w);
    end
    checkEq({name, " y_valid"}, 32'(y_valid), 32'(sbQueue.size() != 0));
    checkEq({name, " busy"}, 32'(busy), 32'(sbQueue.size() != 0));
    if (sbQueue.size() != 0) begin
      checkEq({name, " y"}, 32'(y), 32'(sbQueue[0].data));
      checkEq({name, " sel"}, 32'(sel), 32'(sbQueue[0].sel));
    end
  endtask

  // Drop rst_n between clock edges while FULL and verify the outputs clear at once.
  task automatic resetMidCycle(input string name);
    applyStimulus(8'h10, $urandom, 1'b0, 1'b0);
    checkOutput(8'h10, {name, " prefill"});
    #2;
    req   = '0;
    rst_n = 1'b0;
    #1;
    checkEq({name, " y"}, 32'(y), 32'h0);
    checkEq({name, " y_valid"}, 32'(y_valid), 32'h0);
    checkEq({name, " sel"}, 32'(sel), 32'h0);
    checkEq({name, " ack"}, 32'(ack), 32'h0);
    sbQueue.delete();
    modelPtr        = '0;
    modelOwnerValid = 1'b0;
    modelOwner      = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b0);
    modelPtr        = '0;
    modelOwnerValid = 1'b0;
    modelOwner      = '0;

    vecs[0] = '{8'h04, 32'h0000_0A00, 1'b1, 8'h04};
    vecs[1] = '{8'h00, 32'h1234_5678, 1'b1, 8'h00};
    vecs[2] = '{8'h03, 32'hFEDC_BA98, 1'b0, 8'h01};
    vecs[3] = '{8'h03, 32'h0F1E_2D3C, 1'b0, 8'h00};
    vecs[4] = '{8'h03, 32'h4B5A_6978, 1'b1, 8'h02};
    vecs[5] = '{8'h80, 32'hC000_0000, 1'b1, 8'h80};
    vecs[6] = '{8'h81, 32'h5000_0006, 1'b1, 8'h01};
    vecs[7] = '{8'h81, 32'h9000_0003, 1'b1, 8'h80};
    vecs[8] = '{8'h00, 32'h0000_0000, 1'b1, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    checkEq("reset y", 32'(y), 32'h0);
    checkEq("reset y_valid", 32'(y_valid), 32'h0);
    checkEq("reset sel", 32'(sel), 32'h0);
    checkEq("reset ack", 32'(ack), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].req, vecs[i].data, vecs[i].rdy, 1'b0);
      checkOutput(vecs[i].expAck, $sformatf("vec%0d", i));
      if (i == 0) begin
        checkEq("single y", 32'(y), 32'hA);
        checkEq("single sel", 32'(sel), 32'd2);
      end
    end

    for (int k = 0; k < 9; k++) begin
      applyStimulus(8'hFF, $urandom, 1'b1, 1'b0);
      checkOutput(8'd1 << (k % 8), $sformatf("rot%0d", k));
      checkEq($sformatf("rot%0d order", k), 32'(sel), 32'(k % 8));
    end
    applyStimulus(8'h00, $urandom, 1'b1, 1'b0);
    checkOutput(8'h00, "rot drain");

    applyStimulus(8'h40, $urandom, 1'b1, 1'b0);
    checkOutput(8'h40, "wrap setup");
    applyStimulus(8'h02, $urandom, 1'b1, 1'b0);
    checkOutput(8'h02, "wrap skip");
    checkEq("wrap sel", 32'(sel), 32'd1);
    applyStimulus(8'hFF, $urandom, 1'b1, 1'b0);
    checkOutput(8'h04, "wrap ptr");
    applyStimulus(8'h00, $urandom, 1'b1, 1'b0);
    checkOutput(8'h00, "wrap drain");

    applyStimulus(8'h01, $urandom, 1'b0, 1'b0);
    checkOutput(8'h01, "bp fill");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(8'h81, $urandom, 1'b0, 1'b0);
      checkOutput(8'h00, $sformatf("bp hold%0d", k));
      checkEq($sformatf("bp sel%0d", k), 32'(sel), 32'd0);
    end
    applyStimulus(8'h81, $urandom, 1'b1, 1'b0);
    checkOutput(8'h80, "bp release");
    applyStimulus(8'h81, $urandom, 1'b1, 1'b0);
    checkOutput(8'h01, "bp next");
    applyStimulus(8'h00, $urandom, 1'b1, 1'b0);
    checkOutput(8'h00, "bp drain");

    resetMidCycle("midreset");
    applyStimulus(8'hFF, $urandom, 1'b1, 1'b0);
    checkOutput(8'h01, "post-reset ptr");
    applyStimulus(8'h00, $urandom, 1'b1, 1'b0);
    checkOutput(8'h00, "post-reset drain");

`ifdef ARB_LOCK_EN
    resetMidCycle("lockreset");
    applyStimulus(8'h09, $urandom, 1'b1, 1'b1);
    checkOutput(8'h01, "lock take");
    applyStimulus(8'h09, $urandom, 1'b1, 1'b1);
    checkOutput(8'h01, "lock hold");
    applyStimulus(8'h08, $urandom, 1'b1, 1'b1);
    checkOutput(8'h00, "lock block");
    applyStimulus(8'h09, $urandom, 1'b1, 1'b0);
    checkOutput(8'h01, "lock release");
    applyStimulus(8'h09, $urandom, 1'b1, 1'b0);
    checkOutput(8'h08, "lock next");
    applyStimulus(8'h00, $urandom, 1'b1, 1'b0);
    checkOutput(8'h00, "lock drain");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
